// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - sequential shift/rotate unit, one log2 barrel stage per clock
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only while idle
//   op                  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   In1, In2            operand and unsigned shift amount
//   S, Flag             flag-update enable and current flags {N,Z,C,V}
//   out_valid/out_ready result handshake
//   Result, New_Flag    shifted value and updated flags, held until accepted
//
// Build option: SHIFT_UNIT_RRX_EN makes ROR by 0 perform RRX (rotate through carry).
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] In1,
    input  logic [SHW-1:0]   In2,
    input  logic             S,
    input  logic [3:0]       Flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       New_Flag
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // FIN is the writeback cycle that forms Result/New_Flag after the last stage.
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FIN, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     stage_q, stage_d;
    logic [1:0]         op_q, op_d;
    logic [SHW-1:0]     amt_q, amt_d;
    logic               s_q, s_d;
    logic [3:0]         flag_q, flag_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               carry_q, carry_d;
    logic               cvalid_q, cvalid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         new_flag_q, new_flag_d;
    logic               out_valid_q, out_valid_d;

    // Per-stage shift datapath
    logic [SHW-1:0]     shamt;
    logic [SHW-1:0]     idx_lsl;
    logic [SHW-1:0]     idx_r;
    logic [WIDTH-1:0]   rot_val;
    logic [WIDTH-1:0]   stage_val;
    logic               stage_c;

    // Writeback datapath
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c;

    always_comb begin
        shamt   = SHW'(1) << stage_q;
        // WIDTH is a power of two, so WIDTH-shamt fits in SHW bits for shamt >= 1.
        idx_lsl = SHW'(WIDTH - int'(shamt));
        idx_r   = shamt - SHW'(1);
        rot_val = (work_q >> shamt) | (work_q << idx_lsl);
        case (op_q)
            OP_LSL: begin
                stage_val = work_q << shamt;
                stage_c   = work_q[idx_lsl];
            end
            OP_LSR: begin
                stage_val = work_q >> shamt;
                stage_c   = work_q[idx_r];
            end
            OP_ASR: begin
                stage_val = $signed(work_q) >>> shamt;
                stage_c   = work_q[idx_r];
            end
            default: begin
                stage_val = rot_val;
                stage_c   = rot_val[WIDTH-1];
            end
        endcase
    end

    always_comb begin
        fin_res = work_q;
        // With no active stage the carry flag passes through untouched.
        fin_c   = cvalid_q ? carry_q : flag_q[1];
`ifdef SHIFT_UNIT_RRX_EN
        if (op_q == OP_ROR && amt_q == '0) begin
            fin_res = {flag_q[1], work_q[WIDTH-1:1]};
            fin_c   = work_q[0];
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        op_d        = op_q;
        amt_d       = amt_q;
        s_d         = s_q;
        flag_d      = flag_q;
        work_d      = work_q;
        carry_d     = carry_q;
        cvalid_d    = cvalid_q;
        result_d    = result_q;
        new_flag_d  = new_flag_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = op;
                    amt_d    = In2;
                    s_d      = S;
                    flag_d   = Flag;
                    work_d   = In1;
                    stage_d  = '0;
                    carry_d  = 1'b0;
                    cvalid_d = 1'b0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (amt_q[stage_q]) begin
                    work_d   = stage_val;
                    carry_d  = stage_c;
                    cvalid_d = 1'b1;
                end
                if (stage_q == SHW'(SHW - 1)) begin
                    state_d = ST_FIN;
                end else begin
                    stage_d = stage_q + SHW'(1);
                end
            end
            ST_FIN: begin
                result_d    = fin_res;
                new_flag_d  = s_q ? {fin_res[WIDTH-1], fin_res == '0, fin_c, flag_q[0]} : flag_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            op_q        <= '0;
            amt_q       <= '0;
            s_q         <= 1'b0;
            flag_q      <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            cvalid_q    <= 1'b0;
            result_q    <= '0;
            new_flag_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            s_q         <= s_d;
            flag_q      <= flag_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            cvalid_q    <= cvalid_d;
            result_q    <= result_d;
            new_flag_q  <= new_flag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign New_Flag  = new_flag_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - scoreboard testbench for shift_unit_seq
module tb_shift_unit_seq;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  In1;
    logic [SW-1:0] In2;
    logic          S;
    logic [3:0]    Flag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Result;
    logic [3:0]    New_Flag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        time          t_acc;
        int           stall;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(W), .SHW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .In1       (In1),
        .In2       (In2),
        .S         (S),
        .Flag      (Flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .New_Flag  (New_Flag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Whole-amount reference: shift by n in one step, carry is the last bit out.
    function automatic logic [W+3:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input int n, input logic s, input logic [3:0] f);
        logic [W-1:0] r;
        logic         c;
        c = f[1];
        case (o)
            2'b00: begin r = a << n; if (n > 0) c = a[W-n]; end
            2'b01: begin r = a >> n; if (n > 0) c = a[n-1]; end
            2'b10: begin r = $signed(a) >>> n; if (n > 0) c = a[n-1]; end
            default: begin
                r = (a >> n) | (a << (W - n));
                if (n > 0) c = r[W-1];
            end
        endcase
`ifdef SHIFT_UNIT_RRX_EN
        if (o == 2'b11 && n == 0) begin
            r = {f[1], a[W-1:1]};
            c = a[0];
        end
`endif
        return s ? {r, r[W-1], (r == '0), c, f[0]} : {r, f};
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [SW-1:0] n,
                         input logic s, input logic [3:0] f, input int stall);
        int   guard;
        exp_t e;
        logic [W+3:0] m;
        guard = 0;
        @(negedge clk);
        op = o; In1 = a; In2 = n; S = s; Flag = f; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m       = model(o, a, int'(n), s, f);
        e.res   = m[W+3:4];
        e.fl    = m[3:0];
        e.t_acc = $time;
        e.stall = stall;
        exp_q.push_back(e);
        #1;
        // Scramble the inputs: the latched operation must not see these.
        in_valid = 1'b0;
        op   = 2'($urandom);
        In1  = $urandom;
        In2  = SW'($urandom);
        S    = 1'($urandom);
        Flag = 4'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        rst = 1'b1; in_valid = 1'b0; op = '0; In1 = '0; In2 = '0; S = 1'b0; Flag = '0;
        out_ready = 1'b0;

        fork
            begin : monitor
                bit           have;
                int           wl;
                exp_t         cur;
                logic [W-1:0] hr;
                logic [3:0]   hf;
                have = 0;
                wl   = 0;
                forever begin
                    @(negedge clk);
                    if (out_valid) begin
                        chk("in_ready_done", {63'd0, in_ready}, 64'd0);
                        if (!have) begin
                            have = 1;
                            if (exp_q.size() == 0) begin
                                chk("unexpected_out", {63'd0, out_valid}, 64'd0);
                                wl = 0;
                            end else begin
                                cur = exp_q.pop_front();
                                chk("result", {32'd0, Result}, {32'd0, cur.res});
                                chk("flags", {60'd0, New_Flag}, {60'd0, cur.fl});
                                chk("latency", $time - cur.t_acc, 64'd65);
                                wl = cur.stall;
                            end
                            hr = Result;
                            hf = New_Flag;
                        end else begin
                            chk("result_hold", {32'd0, Result}, {32'd0, hr});
                            chk("flags_hold", {60'd0, New_Flag}, {60'd0, hf});
                        end
                        if (wl > 0) begin
                            out_ready = 1'b0;
                            wl--;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end else begin
                        if (have) chk("idle_after_handshake", {63'd0, in_ready}, 64'd1);
                        have = 0;
                        out_ready = 1'b0;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_result", {32'd0, Result}, 64'd0);
        chk("rst_flags", {60'd0, New_Flag}, 64'd0);
        rst = 1'b0;

        issue(2'b11, 32'h0000_0002, 5'd3, 1'b1, 4'b0000, 0);
        issue(2'b11, 32'hFFFF_FFFF, 5'd9, 1'b1, 4'b0000, 0);
        issue(2'b01, 32'h0000_0001, 5'd1, 1'b1, 4'b0000, 0);
        issue(2'b00, 32'h8000_0001, 5'd1, 1'b1, 4'b0000, 0);
        issue(2'b10, 32'hFFFF_FFFA, 5'd2, 1'b0, 4'b0001, 0);
        issue(2'b00, 32'h1234_5678, 5'd4, 1'b1, 4'b0000, 5);
        issue(2'b11, 32'h0000_0001, 5'd0, 1'b1, 4'b0010, 1);
        issue(2'b00, 32'hDEAD_BEEF, 5'd0, 1'b1, 4'b0010, 0);
        issue(2'b01, 32'h8000_0000, 5'd0, 1'b1, 4'b0001, 0);
        issue(2'b10, 32'h8000_0000, 5'd31, 1'b1, 4'b0000, 0);

        // Reset in the middle of an operation: accept, then two stage edges.
        issue(2'b00, 32'hFFFF_0000, 5'd7, 1'b1, 4'b0000, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_result", {32'd0, Result}, 64'd0);
        chk("midrst_flags", {60'd0, New_Flag}, 64'd0);
        exp_q.delete();
        issue(2'b10, 32'h8000_0000, 5'd31, 1'b1, 4'b0100, 0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), $urandom, SW'($urandom), 1'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)));
        end

        g = 0;
        while (exp_q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
